pipeio_responder: RTL

- Memory-mapped I/O responder on the CPU's MEM-stage data bus; the target end of the CPU's store/load accesses to I/O space.
- Synchronises and debounces the two 6-bit input ports and latches change flags.
- Holds the four 32-bit output port registers.
- Returns read data combinationally so the MEM stage can latch it into MEM/WB on the next rising edge.

---
 rtl/pipeio_responder_pkg.sv | 25 ++
 rtl/pipeio_responder_if.sv | 11 +
 rtl/pipeio_debounce.sv | 51 +++++
 rtl/pipeio_responder.sv | 118 +++++++++++
 4 files changed

// File: rtl/pipeio_responder_pkg.sv
// Shared constants for the MEM-stage I/O responder: word offsets of the
// register map, STAT bit positions and the I/O-space address decode.
package pipeio_responder_pkg;

  // Word offsets, i.e. addr[4:2]
  localparam logic [2:0] OFS_IN0   = 3'd0;
  localparam logic [2:0] OFS_IN1   = 3'd1;
  localparam logic [2:0] OFS_STAT  = 3'd2;
  localparam logic [2:0] OFS_TIMER = 3'd3;
  localparam logic [2:0] OFS_OUT0  = 3'd4;
  localparam logic [2:0] OFS_OUT1  = 3'd5;
  localparam logic [2:0] OFS_OUT2  = 3'd6;
  localparam logic [2:0] OFS_OUT3  = 3'd7;

  localparam int unsigned STAT_IN0 = 0;
  localparam int unsigned STAT_IN1 = 1;

  // The I/O window is the 32-byte block selected by addr[7:5] below address 0x100
  localparam int unsigned IO_DECODE_LSB = 5;

  function automatic logic io_hit(input logic [31:0] addr, input logic [7:0] base);
    return (addr[31:8] == 24'h0) && (addr[7:IO_DECODE_LSB] == base[7:IO_DECODE_LSB]);
  endfunction

endpackage

// File: rtl/pipeio_responder_if.sv
// MEM-stage data bus between the CPU (master) and the I/O responder (slave).
interface pipeio_responder_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        io_sel;
  logic [31:0] rdata;

  modport master (output we, output addr, output wdata, input io_sel, input rdata);
  modport slave  (input we, input addr, input wdata, output io_sel, output rdata);
endinterface

// File: rtl/pipeio_debounce.sv
// One 6-bit input port: 2-flop synchroniser, stability counter and accepted value.
// changed_o pulses in the cycle whose rising edge loads the new stable value.
module pipeio_debounce #(
  parameter int unsigned DbCycles = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] pin_i,
  output logic [5:0] stable_o,
  output logic       changed_o
);

  localparam logic [7:0] CntLast = 8'(DbCycles - 1);

  logic [5:0] sync1_q, sync2_q;
  logic [5:0] stable_q, stable_d;
  logic [7:0] cnt_q, cnt_d;

  // A change to a third value keeps counting; whatever is synced at acceptance wins
  always_comb begin
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    changed_o = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      stable_d  = sync2_q;
      cnt_d     = '0;
      changed_o = 1'b1;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= pin_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/pipeio_responder.sv
// Memory-mapped I/O responder: debounced inputs, W1C change flags, four output
// registers; PIPEIO_FREE_TIMER_EN adds a free-running 32-bit TIMER register.
module pipeio_responder
  import pipeio_responder_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16,
  parameter logic [7:0]  IO_BASE   = 8'h80
) (
  input  logic                      clock,
  input  logic                      resetn,
  pipeio_responder_if.slave         bus,
  input  logic [5:0]                in_port0,
  input  logic [5:0]                in_port1,
  output logic [31:0]               out_port0,
  output logic [31:0]               out_port1,
  output logic [31:0]               out_port2,
  output logic [31:0]               out_port3
);

  logic [5:0]       stable0, stable1;
  logic             chg0, chg1;
  logic [2:0]       ofs;
  logic             wr_en;
  logic [3:0][31:0] out_q, out_d;
  logic [1:0]       stat_q, stat_d;
  logic [31:0]      timer_rd;
  logic             unused_addr;

  pipeio_debounce #(.DbCycles(DB_CYCLES)) u_db0 (
    .clk_i     (clock),
    .rst_ni    (resetn),
    .pin_i     (in_port0),
    .stable_o  (stable0),
    .changed_o (chg0)
  );

  pipeio_debounce #(.DbCycles(DB_CYCLES)) u_db1 (
    .clk_i     (clock),
    .rst_ni    (resetn),
    .pin_i     (in_port1),
    .stable_o  (stable1),
    .changed_o (chg1)
  );

  assign bus.io_sel  = io_hit(bus.addr, IO_BASE);
  assign ofs         = bus.addr[4:2];
  assign wr_en       = bus.we && bus.io_sel;
  assign unused_addr = ^bus.addr[1:0];

  // OUT0..OUT3 occupy the upper half of the offset space, so ofs[2] selects them
  always_comb begin
    out_d  = out_q;
    stat_d = stat_q;
    if (wr_en) begin
      if (ofs[2]) begin
        out_d[ofs[1:0]] = bus.wdata;
      end
      if (ofs == OFS_STAT) begin
        stat_d = stat_q & ~bus.wdata[1:0];
      end
    end
    // Setting after the clear makes a same-cycle set win
    if (chg0) stat_d[STAT_IN0] = 1'b1;
    if (chg1) stat_d[STAT_IN1] = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_q  <= '0;
      stat_q <= '0;
    end else begin
      out_q  <= out_d;
      stat_q <= stat_d;
    end
  end

`ifdef PIPEIO_FREE_TIMER_EN
  logic [31:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q + 32'd1;
    if (wr_en && (ofs == OFS_TIMER)) begin
      timer_d = bus.wdata;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  always_comb begin
    bus.rdata = '0;
    if (bus.io_sel) begin
      case (ofs)
        OFS_IN0:   bus.rdata = {26'b0, stable0};
        OFS_IN1:   bus.rdata = {26'b0, stable1};
        OFS_STAT:  bus.rdata = {30'b0, stat_q};
        OFS_TIMER: bus.rdata = timer_rd;
        default:   bus.rdata = out_q[ofs[1:0]];
      endcase
    end
  end

  assign out_port0 = out_q[0];
  assign out_port1 = out_q[1];
  assign out_port2 = out_q[2];
  assign out_port3 = out_q[3];

endmodule
